multi_crop_stream: RTL and testbench
====================================

# multi_crop_stream

Streaming multi-window crop engine, the parametrised successor to the single-window crop front end of `crop_plus_gaussian`. It accepts one raster-order frame of IN_ROWS×IN_COLS pixels over an AXI-Stream-style input. It emits NUM_CROPS independent OUT_ROWS×OUT_COLS windows, one output stream per window, with offsets programmable per frame. Windows may overlap; every input pixel is read exactly once and fanned out to each window containing it. Control uses the ap_start/ap_done/ap_idle/ap_ready handshake of the downstream CNN wrapper.

## Interface
Parameters:
- PIXEL_BIT_WIDTH, 16, pixel width
- IN_ROWS, 100; IN_COLS, 160, input frame size
- OUT_ROWS, 48; OUT_COLS, 48, window size (≤ input size)
- NUM_CROPS, 2, number of windows/output channels (1..8)

Ports:
- ap_clk  in  1  clock. One clock; all logic on rising edge.
- ap_rst_n  in  1  reset. Synchronous, active-low.
- ap_start  in  1  frame start, sampled in IDLE only
- ap_done  out  1  one-cycle pulse, frame fully drained
- ap_idle  out  1  high in IDLE
- ap_ready  out  1  one-cycle pulse on acceptance of last input pixel
- crop_y  in  NUM_CROPS*YW  per-window top row, YW=$clog2(IN_ROWS); latched at start
- crop_x  in  NUM_CROPS*XW  per-window left column, XW=$clog2(IN_COLS); latched at start
- crop_input_TDATA  in  PIXEL_BIT_WIDTH  pixel
- crop_input_TVALID  in  1; crop_input_TREADY  out  1
- crop_output_TDATA  out  NUM_CROPS*PIXEL_BIT_WIDTH  channel c at bits [c*W +: W]
- crop_output_TVALID  out  NUM_CROPS; crop_output_TREADY  in  NUM_CROPS

## Operation
- FSM states: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: on ap_start=1, latch crop_y/crop_x, zero row/col counters, go to RUN.
  - Offsets are clamped on latch: y>IN_ROWS−OUT_ROWS becomes IN_ROWS−OUT_ROWS; x likewise with IN_COLS−OUT_COLS.
- RUN: counters (r,c) track the position of the next input pixel.
  - in_win[k] = (r−y_k < OUT_ROWS) && (c−x_k < OUT_COLS), computed with unsigned compare after subtract.
  - crop_input_TREADY = RUN && ∀k: !in_win[k] || !out_valid[k] || crop_output_TREADY[k]. This is a combinational path from the output TREADYs; do not register it.
  - On input accept, TDATA is loaded into out_reg[k] for every k with in_win[k], and out_valid[k] is set. Pixels outside all windows are consumed and dropped.
  - Counters advance c++ with wrap to 0 and r++ at IN_COLS−1.
  - Accepting pixel (IN_ROWS−1, IN_COLS−1) pulses ap_ready and moves to DRAIN.
- Output channel k: out_valid[k] clears on TVALID&TREADY unless reloaded the same cycle. A simultaneous drain and load keeps valid=1 with new data.
- DRAIN: wait until all out_valid are 0, then go to DONE.
- DONE: ap_done=1 for one cycle, then IDLE. ap_start during RUN, DRAIN or DONE is ignored.
- Each channel emits exactly OUT_ROWS*OUT_COLS beats per frame, in raster order.

## Timing
- Reset values:
  - FSM=IDLE, ap_idle=1.
  - ap_done=0, ap_ready=0.
  - crop_input_TREADY=0, all crop_output_TVALID=0, TDATA=0.
  - Counters=0, latched offsets=0.
- Reset mid-frame: the partial frame is discarded; no beat is emitted after the reset cycle.
- Latency: 1 cycle from input accept to output TVALID.
- Throughput: 1 pixel/cycle while all needed channels are ready.
- TVALID holds, with TDATA stable, until TREADY is high.
- ap_start to first possible TREADY: 1 cycle.
- ap_done comes no earlier than 1 cycle after the last output beat handshakes.

## Structure
- Package `crop_pkg` holds:
  - fsm_state_t enum;
  - the clamp function;
  - localparams YW, XW, and FRAME_PIXELS=IN_ROWS*IN_COLS.
- Sub-module `crop_channel`: a one-entry output register per window, holding the window compare, valid/data register and drain logic. It is instantiated NUM_CROPS times in a generate loop.
- The top level holds the FSM, counters, offset latch and TREADY AND-reduction.

## Test plan
In all scenarios pixel value = r*IN_COLS+c, with default parameters unless stated.
- Two disjoint windows at (10,10) and (40,100), all ready high:
  - ch0 emits 2304 beats, 1610 first and 9177 last;
  - ch1 emits 6500 first and 14067 last;
  - ap_done fires once.
- Overlapping windows at (10,10) and (20,20): pixel 3220 appears on both channels in the same cycle; both channels have correct beat counts.
- Backpressure: hold crop_output_TREADY[1]=0 after its first beat.
  - crop_input_TREADY drops at the next pixel inside window 1.
  - TDATA[1] stays stable and ch0 does not advance.
  - Releasing TREADY resumes the stream with no loss or duplication.
- Randomised valid/ready on all streams over 4 frames: per-channel sequence matches the golden model and ap_done count is 4.
- Offset clamp: crop_y=80, crop_x=150 give an effective offset of (52,112); the first beat is 8432.
- Mid-frame reset after 5000 input beats: all outputs reach reset values next cycle. A new ap_start then yields a complete, correct frame.

Source files
------------

// File: rtl/crop_pkg.sv
// Shared FSM type, offset clamp and default frame geometry for the multi-window crop engine.
// YW/XW/FRAME_PIXELS describe the default 100x160 frame; parametrised tops derive their own widths.
package crop_pkg;

    localparam int DEF_IN_ROWS  = 100;
    localparam int DEF_IN_COLS  = 160;
    localparam int DEF_OUT_ROWS = 48;
    localparam int DEF_OUT_COLS = 48;

    localparam int YW           = $clog2(DEF_IN_ROWS);
    localparam int XW           = $clog2(DEF_IN_COLS);
    localparam int FRAME_PIXELS = DEF_IN_ROWS * DEF_IN_COLS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fsm_state_t;

    // Keeps a window fully inside the frame by pulling oversized offsets back to the last legal one.
    function automatic int clamp_offset(input int offset, input int max_offset);
        return (offset > max_offset) ? max_offset : offset;
    endfunction

endpackage

// File: rtl/crop_channel.sv
// One output window: window membership test plus a single-entry valid/data register
// that loads on input accept and drains on its own TVALID/TREADY handshake.
module crop_channel #(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int OUT_ROWS        = 48,
    parameter int OUT_COLS        = 48,
    parameter int Y_W             = 7,
    parameter int X_W             = 8
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [Y_W-1:0]             row,
    input  logic [X_W-1:0]             col,
    input  logic [Y_W-1:0]             win_y,
    input  logic [X_W-1:0]             win_x,
    input  logic                       accept,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel,
    output logic                       stall,
    output logic [PIXEL_BIT_WIDTH-1:0] tdata,
    output logic                       tvalid,
    input  logic                       tready
);

    logic [Y_W-1:0] dy;
    logic [X_W-1:0] dx;
    logic           in_win;
    logic           load;

    // Positions left of / above the window wrap to large values, so one compare per axis suffices.
    assign dy     = row - win_y;
    assign dx     = col - win_x;
    assign in_win = (int'(dy) < OUT_ROWS) && (int'(dx) < OUT_COLS);

    assign load  = accept && in_win;
    assign stall = in_win && tvalid && !tready;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            tvalid <= 1'b0;
            // NOTE: the pixel register is reset as well so TDATA reads zero straight out of reset.
            tdata  <= '0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= pixel;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_crop_stream.sv
// Streaming crop engine: reads one raster frame once and fans each pixel out to every
// window containing it; ap_* handshake FSM, raster counters and per-frame offset latch live here.
module multi_crop_stream
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 16,
    parameter int IN_ROWS         = DEF_IN_ROWS,
    parameter int IN_COLS         = DEF_IN_COLS,
    parameter int OUT_ROWS        = DEF_OUT_ROWS,
    parameter int OUT_COLS        = DEF_OUT_COLS,
    parameter int NUM_CROPS       = 2
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst_n,
    input  logic                                 ap_start,
    output logic                                 ap_done,
    output logic                                 ap_idle,
    output logic                                 ap_ready,
    input  logic [NUM_CROPS*$clog2(IN_ROWS)-1:0] crop_y,
    input  logic [NUM_CROPS*$clog2(IN_COLS)-1:0] crop_x,
    input  logic [PIXEL_BIT_WIDTH-1:0]           crop_input_TDATA,
    input  logic                                 crop_input_TVALID,
    output logic                                 crop_input_TREADY,
    output logic [NUM_CROPS*PIXEL_BIT_WIDTH-1:0] crop_output_TDATA,
    output logic [NUM_CROPS-1:0]                 crop_output_TVALID,
    input  logic [NUM_CROPS-1:0]                 crop_output_TREADY
);

    localparam int Y_W   = $clog2(IN_ROWS);
    localparam int X_W   = $clog2(IN_COLS);
    localparam int MAX_Y = IN_ROWS - OUT_ROWS;
    localparam int MAX_X = IN_COLS - OUT_COLS;

    fsm_state_t           state_q, state_d;
    logic [Y_W-1:0]       row_q;
    logic [X_W-1:0]       col_q;
    logic [Y_W-1:0]       win_y_q [NUM_CROPS];
    logic [X_W-1:0]       win_x_q [NUM_CROPS];
    logic [NUM_CROPS-1:0] stall;
    logic                 accept;
    logic                 last_col;
    logic                 last_pixel;
    logic                 start_frame;

    assign last_col    = (col_q == X_W'(IN_COLS - 1));
    assign last_pixel  = last_col && (row_q == Y_W'(IN_ROWS - 1));
    assign start_frame = (state_q == ST_IDLE) && ap_start;

    // Input is held only while some window wants this pixel and its register cannot take it.
    assign crop_input_TREADY = (state_q == ST_RUN) && !(|stall);
    assign accept            = crop_input_TREADY && crop_input_TVALID;

    assign ap_ready = accept && last_pixel;
    assign ap_idle  = (state_q == ST_IDLE);
    assign ap_done  = (state_q == ST_DONE);

    always_ff @(posedge ap_clk) begin
        // NOTE: all sequential state uses <= so every flop sees pre-edge values regardless of block order.
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: next state defaults to hold before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (ap_start)              state_d = ST_RUN;
            ST_RUN:   if (accept && last_pixel)  state_d = ST_DRAIN;
            ST_DRAIN: if (~|crop_output_TVALID)  state_d = ST_DONE;
            ST_DONE:                             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            row_q <= '0;
            col_q <= '0;
            // NOTE: the offset latch is plain flops rather than a memory, so clearing it in a loop is fine.
            for (int k = 0; k < NUM_CROPS; k++) begin
                win_y_q[k] <= '0;
                win_x_q[k] <= '0;
            end
        end else if (start_frame) begin
            row_q <= '0;
            col_q <= '0;
            for (int k = 0; k < NUM_CROPS; k++) begin
                win_y_q[k] <= Y_W'(clamp_offset(int'(crop_y[k*Y_W +: Y_W]), MAX_Y));
                win_x_q[k] <= X_W'(clamp_offset(int'(crop_x[k*X_W +: X_W]), MAX_X));
            end
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_pixel ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CROPS; k++) begin : g_ch
        crop_channel #(
            .PIXEL_BIT_WIDTH (PIXEL_BIT_WIDTH),
            .OUT_ROWS        (OUT_ROWS),
            .OUT_COLS        (OUT_COLS),
            .Y_W             (Y_W),
            .X_W             (X_W)
        ) u_channel (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .row      (row_q),
            .col      (col_q),
            .win_y    (win_y_q[k]),
            .win_x    (win_x_q[k]),
            .accept   (accept),
            .pixel    (crop_input_TDATA),
            .stall    (stall[k]),
            .tdata    (crop_output_TDATA[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH]),
            .tvalid   (crop_output_TVALID[k]),
            .tready   (crop_output_TREADY[k])
        );
    end

endmodule

// File: tb/tb_multi_crop_stream.sv
// Directed bench for multi_crop_stream: disjoint windows with backpressure, offset clamp,
// mid-frame reset, overlapping windows, and a random-handshake frame. Pixel value = r*160+c.
`timescale 1ns/1ps
module tb_multi_crop_stream;
    import crop_pkg::*;

    localparam int W        = 16;
    localparam int NC       = 2;
    localparam int IN_COLS  = 160;
    localparam int OUT_COLS = 48;
    localparam int MAX_Y    = 52;
    localparam int MAX_X    = 112;
    localparam int BEATS    = 48 * 48;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [NC*YW-1:0]  crop_y;
    logic [NC*XW-1:0]  crop_x;
    logic [W-1:0]      in_tdata;
    logic              in_tvalid;
    logic              in_tready;
    logic [NC*W-1:0]   out_tdata;
    logic [NC-1:0]     out_tvalid;
    logic [NC-1:0]     out_tready;

    multi_crop_stream dut (
        .ap_clk             (ap_clk),
        .ap_rst_n           (ap_rst_n),
        .ap_start           (ap_start),
        .ap_done            (ap_done),
        .ap_idle            (ap_idle),
        .ap_ready           (ap_ready),
        .crop_y             (crop_y),
        .crop_x             (crop_x),
        .crop_input_TDATA   (in_tdata),
        .crop_input_TVALID  (in_tvalid),
        .crop_input_TREADY  (in_tready),
        .crop_output_TDATA  (out_tdata),
        .crop_output_TVALID (out_tvalid),
        .crop_output_TREADY (out_tready)
    );

    always #5 ap_clk = ~ap_clk;

    int checks, errors;
    int beats [NC], first_px [NC], last_px [NC], seq_err [NC], proto_err [NC], hit_cyc [NC];
    int exp_y [NC], exp_x [NC];
    int done_cnt, ready_cnt, ready_bad, cyc, done_cyc, last_beat_cyc;
    logic [NC-1:0] prev_stall;
    logic [W-1:0]  prev_data [NC];
    bit            feed_en, rdy_rand, in_hs;
    int            vprob, feed_idx;
    logic [NC-1:0] rdy_hold;

    // Monitor: everything is sampled mid-cycle, so a handshake seen here completes at the next edge.
    always @(negedge ap_clk) begin
        cyc++;
        in_hs = in_tvalid && in_tready;
        if (ap_rst_n) begin
            if (ap_done) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (ap_ready) begin
                ready_cnt++;
                if (int'(in_tdata) != FRAME_PIXELS - 1) ready_bad++;
            end
            for (int k = 0; k < NC; k++) begin
                automatic logic [W-1:0] d = out_tdata[k*W +: W];
                automatic int e;
                if (prev_stall[k] && (!out_tvalid[k] || d !== prev_data[k])) proto_err[k]++;
                prev_stall[k] = out_tvalid[k] && !out_tready[k];
                prev_data[k]  = d;
                if (out_tvalid[k] && out_tready[k]) begin
                    e = (exp_y[k] + beats[k] / OUT_COLS) * IN_COLS + exp_x[k] + beats[k] % OUT_COLS;
                    if (beats[k] == 0) first_px[k] = int'(d);
                    last_px[k] = int'(d);
                    if (int'(d) != e) seq_err[k]++;
                    if (int'(d) == 3220) hit_cyc[k] = cyc;
                    last_beat_cyc = cyc;
                    beats[k]++;
                end
            end
        end else begin
            prev_stall = '0;
        end
    end

    // Source and sink drivers: update just after the edge, after the main sequence's own updates.
    always @(posedge ap_clk) begin
        #2;
        if (in_hs && feed_en) feed_idx++;
        if (!feed_en || feed_idx >= FRAME_PIXELS) in_tvalid = 1'b0;
        else if (!in_tvalid || in_hs)             in_tvalid = ($urandom_range(99) < vprob);
        in_tdata = W'(feed_idx);
        for (int k = 0; k < NC; k++)
            out_tready[k] = rdy_hold[k] ? 1'b0 : (rdy_rand ? ($urandom_range(99) < 80) : 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic start_frame(input int cy0, input int cx0, input int cy1, input int cx1);
        tick(1);
        crop_y   = {YW'(cy1), YW'(cy0)};
        crop_x   = {XW'(cx1), XW'(cx0)};
        exp_y[0] = (cy0 > MAX_Y) ? MAX_Y : cy0;
        exp_x[0] = (cx0 > MAX_X) ? MAX_X : cx0;
        exp_y[1] = (cy1 > MAX_Y) ? MAX_Y : cy1;
        exp_x[1] = (cx1 > MAX_X) ? MAX_X : cx1;
        for (int k = 0; k < NC; k++) begin
            beats[k] = 0; first_px[k] = -1; last_px[k] = -1;
            seq_err[k] = 0; proto_err[k] = 0; hit_cyc[k] = 0;
        end
        done_cnt = 0; ready_cnt = 0; ready_bad = 0; done_cyc = 0; last_beat_cyc = 0;
        feed_idx = 0; feed_en = 1'b1; ap_start = 1'b1;
        tick(1);
        ap_start = 1'b0;
    endtask

    task automatic wait_beats(input int k, input int n, input int budget, input string tag);
        automatic int t = 0;
        while (beats[k] < n && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, beats[k] >= n, 1);
    endtask

    task automatic wait_fed(input int n, input int budget);
        automatic int t = 0;
        while (feed_idx < n && t < budget) begin
            tick(1);
            t++;
        end
        check("fed_before_reset", feed_idx >= n, 1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        automatic int t = 0;
        while (done_cnt == 0 && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, done_cnt > 0, 1);
        tick(3);
    endtask

    task automatic check_frame(input string tag, input int f0, input int l0, input int f1, input int l1);
        check({tag, "_beats0"}, beats[0], BEATS);
        check({tag, "_beats1"}, beats[1], BEATS);
        check({tag, "_first0"}, first_px[0], f0);
        check({tag, "_last0"},  last_px[0], l0);
        check({tag, "_first1"}, first_px[1], f1);
        check({tag, "_last1"},  last_px[1], l1);
        check({tag, "_seq0"},   seq_err[0], 0);
        check({tag, "_seq1"},   seq_err[1], 0);
        check({tag, "_proto"},  proto_err[0] + proto_err[1], 0);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_ready_once"}, ready_cnt, 1);
        check({tag, "_ready_on_last"}, ready_bad, 0);
        check({tag, "_done_after_last_beat"}, done_cyc > last_beat_cyc, 1);
    endtask

    int beats_snap;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int k = 0; k < NC; k++) begin
            beats[k] = 0; exp_y[k] = 0; exp_x[k] = 0; proto_err[k] = 0; seq_err[k] = 0;
        end
        done_cnt = 0; ready_cnt = 0; ready_bad = 0;
        prev_stall = '0; feed_en = 1'b0; feed_idx = 0; vprob = 100;
        rdy_rand = 1'b0; rdy_hold = '0; in_hs = 1'b0;
        ap_rst_n = 1'b0; ap_start = 1'b0; crop_y = '0; crop_x = '0;
        in_tvalid = 1'b0; in_tdata = '0; out_tready = '1;

        // Reset state.
        tick(3);
        @(negedge ap_clk);
        check("rst_idle", ap_idle, 1);
        check("rst_done", ap_done, 0);
        check("rst_ready", ap_ready, 0);
        check("rst_in_tready", in_tready, 0);
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_out_tdata", out_tdata, 0);
        tick(1);
        ap_rst_n = 1'b1;
        tick(2);

        // Disjoint windows; backpressure on ch1 right after its first beat.
        start_frame(10, 10, 40, 100);
        @(negedge ap_clk);
        check("start_to_tready", in_tready, 1);
        check("run_not_idle", ap_idle, 0);
        wait_beats(1, 1, 20000, "bp_first_beat_seen");
        rdy_hold = 2'b10;
        tick(8);
        @(negedge ap_clk);
        check("bp_in_tready_low", in_tready, 0);
        check("bp_ch1_valid_held", out_tvalid[1], 1);
        check("bp_ch1_data_stable", out_tdata[31:16], 6501);
        check("bp_ch1_beats", beats[1], 1);
        check("bp_ch0_frozen", beats[0], 1488);
        check("bp_input_stalled_at", feed_idx, 6502);
        tick(1);
        rdy_hold = '0;
        wait_done(40000, "f1_done_seen");
        check_frame("f1", 1610, 9177, 6500, 14067);
        @(negedge ap_clk);
        check("f1_back_to_idle", ap_idle, 1);

        // Offset clamp: (80,150) behaves as (52,112); frame abandoned by reset afterwards.
        tick(1);
        start_frame(80, 150, 0, 0);
        wait_beats(0, 1, 20000, "clamp_first_beat_seen");
        check("clamp_first0", first_px[0], 8432);
        check("clamp_first1", first_px[1], 0);
        check("clamp_seq1", seq_err[1], 0);
        ap_rst_n = 1'b0;
        feed_en  = 1'b0;
        tick(2);
        ap_rst_n = 1'b1;
        tick(2);

        // Mid-frame reset after 5000 accepted input beats.
        start_frame(10, 10, 20, 20);
        wait_fed(5000, 20000);
        ap_rst_n = 1'b0;
        feed_en  = 1'b0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        check("mid_rst_tvalid", out_tvalid, 0);
        check("mid_rst_tdata", out_tdata, 0);
        check("mid_rst_in_tready", in_tready, 0);
        check("mid_rst_idle", ap_idle, 1);
        check("mid_rst_done", ap_done, 0);
        beats_snap = beats[0] + beats[1];
        tick(3);
        check("mid_rst_no_beats", beats[0] + beats[1], beats_snap);
        ap_rst_n = 1'b1;
        tick(2);

        // Full frame after reset with overlapping windows: shared pixel 3220 leaves both together.
        start_frame(10, 10, 20, 20);
        wait_done(40000, "f4_done_seen");
        check_frame("f4", 1610, 9177, 3220, 10787);
        check("overlap_hit_seen", hit_cyc[0] > 0, 1);
        check("overlap_same_cycle", hit_cyc[1], hit_cyc[0]);

        // Random valid/ready on every stream; windows at the top-left and bottom-right corners.
        rdy_rand = 1'b1;
        vprob    = 85;
        start_frame(0, 0, 52, 112);
        wait_done(60000, "f5_done_seen");
        check_frame("f5", 0, 7567, 8432, 15999);
        rdy_rand = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
